// File: rtl/ro_freq_counter.sv
// ro_freq_counter: Wishbone-mapped ring-oscillator frequency counter.
// Counts synchronized rising edges of ro_in over a programmable gate window,
// with single-shot or continuous measurement and an abort control.
// Optional macro RO_FREQ_COUNTER_IRQ_EN adds CTRL.IE and the irq_o output.
// Note: ro_in above wb_clk_i/2 aliases and is not detected.
module ro_freq_counter #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int unsigned CNT_W    = 24,
  parameter int unsigned GATE_W   = 20
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
`ifdef RO_FREQ_COUNTER_IRQ_EN
  output logic        irq_o,
`endif
  input  logic        ro_in,
  output logic [3:0]  ro_sel_o
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_GATE   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                s1_q, s2_q, s3_q;
  logic                edge_c;
  logic [GATE_W-1:0]   gate_q, gate_d;
  logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_int_q, ovf_int_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                cont_q, cont_d;
  logic [3:0]          sel_q, sel_d;
  logic                ie_c;
  logic                ack_q;
  logic [31:0]         dat_q;
  logic [31:0]         rdata_c;
  logic [31:0]         gate_merge_c;
  logic                hit_c, wr_ctrl_c, wr_gate_c, wr_stat_c;
  logic                start_c, abort_c, busy_c;
  logic                load_c, count_en_c, latch_c;
  logic                unused_c;

  assign unused_c  = ^wbs_adr_i[1:0];

  assign hit_c     = wbs_cyc_i & wbs_stb_i & ~ack_q &
                     (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign wr_ctrl_c = hit_c & wbs_we_i & (wbs_adr_i[3:2] == REG_CTRL);
  assign wr_gate_c = hit_c & wbs_we_i & (wbs_adr_i[3:2] == REG_GATE);
  assign wr_stat_c = hit_c & wbs_we_i & (wbs_adr_i[3:2] == REG_STATUS);
  assign start_c   = wr_ctrl_c & wbs_sel_i[0] & wbs_dat_i[0];
  assign abort_c   = wr_ctrl_c & wbs_sel_i[0] & wbs_dat_i[2];
  assign busy_c    = (state_q != ST_IDLE);
  assign edge_c    = s2_q & ~s3_q;

  // Synchronize ro_in and keep one history flop for rising-edge detection
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= ro_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Measurement FSM state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next state; abort overrides everything, including a coincident start
  always_comb begin
    state_d = state_q;
    if (abort_c) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start_c) state_d = (gate_q == '0) ? ST_LATCH : ST_COUNT;
        ST_COUNT: if (gate_cnt_q == GATE_W'(1)) state_d = ST_LATCH;
        ST_LATCH: begin
          if (cont_q) state_d = (gate_q == '0) ? ST_LATCH : ST_COUNT;
          else        state_d = ST_IDLE;
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM control outputs for the counter and result datapath
  always_comb begin
    load_c     = 1'b0;
    count_en_c = 1'b0;
    latch_c    = 1'b0;
    if (!abort_c) begin
      case (state_q)
        ST_IDLE:  load_c = start_c;
        ST_COUNT: count_en_c = 1'b1;
        ST_LATCH: begin
          latch_c = 1'b1;
          load_c  = cont_q;
        end
        default:  ;
      endcase
    end
  end

  // Gate countdown and saturating edge counter
  always_comb begin
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    ovf_int_d  = ovf_int_q;
    if (load_c) begin
      gate_cnt_d = gate_q;
      edge_cnt_d = '0;
      ovf_int_d  = 1'b0;
    end else if (count_en_c) begin
      gate_cnt_d = gate_cnt_q - GATE_W'(1);
      if (edge_c) begin
        if (&edge_cnt_q) ovf_int_d  = 1'b1;
        else             edge_cnt_d = edge_cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_int_q  <= 1'b0;
    end else begin
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_int_q  <= ovf_int_d;
    end
  end

`ifdef RO_FREQ_COUNTER_IRQ_EN
  logic ie_q, ie_d;
  logic irq_q;
  assign ie_c  = ie_q;
  assign irq_o = irq_q;

  // Interrupt enable and registered done interrupt
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= done_q & ie_q;
    end
  end
`else
  assign ie_c = 1'b0;
`endif

  // Software register updates; SEL and GATE are frozen while a measurement runs
  always_comb begin
    cont_d       = cont_q;
    sel_d        = sel_q;
    gate_d       = gate_q;
    done_d       = done_q;
    ovf_d        = ovf_q;
    count_d      = count_q;
`ifdef RO_FREQ_COUNTER_IRQ_EN
    ie_d         = ie_q;
`endif
    gate_merge_c = 32'(gate_q);
    for (int b = 0; b < 4; b++) begin
      if (wbs_sel_i[b]) gate_merge_c[8*b +: 8] = wbs_dat_i[8*b +: 8];
    end
    if (wr_ctrl_c && wbs_sel_i[0]) begin
      cont_d = wbs_dat_i[1];
      if (!busy_c) sel_d = wbs_dat_i[7:4];
`ifdef RO_FREQ_COUNTER_IRQ_EN
      ie_d = wbs_dat_i[3];
`endif
    end
    if (wr_gate_c && !busy_c) gate_d = GATE_W'(gate_merge_c);
    if (latch_c) begin
      count_d = edge_cnt_q;
      ovf_d   = ovf_int_q;
      done_d  = 1'b1;
    end else if (wr_stat_c && wbs_sel_i[0]) begin
      if (wbs_dat_i[1]) done_d = 1'b0;
      if (wbs_dat_i[2]) ovf_d  = 1'b0;
    end
  end

  // Software-visible registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cont_q  <= 1'b0;
      sel_q   <= '0;
      gate_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      cont_q  <= cont_d;
      sel_q   <= sel_d;
      gate_q  <= gate_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  // Read data mux
  always_comb begin
    rdata_c = '0;
    case (wbs_adr_i[3:2])
      REG_CTRL:   rdata_c = {24'h0, sel_q, ie_c, 1'b0, cont_q, 1'b0};
      REG_GATE:   rdata_c = 32'(gate_q);
      REG_COUNT:  rdata_c = 32'(count_q);
      REG_STATUS: rdata_c = {29'h0, ovf_q, done_q, busy_c};
      default:    rdata_c = '0;
    endcase
  end

  // One-wait-state acknowledge with read data valid only alongside ack
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= hit_c;
      dat_q <= (hit_c && !wbs_we_i) ? rdata_c : '0;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign ro_sel_o  = sel_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Self-checking bench for ro_freq_counter: randomized ro_in waveforms are
// recorded per clock and window edge counts are recomputed from that record.
module tb_ro_freq_counter;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned GATE_W = 20;
  localparam int          MAXC   = (1 << CNT_W) - 1;
  localparam int          HN     = 65536;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic        ack;
  logic [31:0] rdat;
  logic        ro_in = 1'b0;
  logic [3:0]  ro_sel;
`ifdef RO_FREQ_COUNTER_IRQ_EN
  logic        irq;
`endif

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  int last_hit = 0;
  int ro_mode = 0;
  int ro_period = 8;
  int ro_ph = 0;
  logic hist [HN];

  always #5 clk = ~clk;

  ro_freq_counter #(.BASE_ADR(BASE), .CNT_W(CNT_W), .GATE_W(GATE_W)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
`ifdef RO_FREQ_COUNTER_IRQ_EN
    .irq_o    (irq),
`endif
    .ro_in    (ro_in),
    .ro_sel_o (ro_sel)
  );

  // Record ro_in as seen at every rising clock edge
  always @(posedge clk) begin
    hist[cyc_cnt % HN] = ro_in;
    cyc_cnt = cyc_cnt + 1;
  end

  // Oscillator stand-in: square wave of ro_period clocks, or random bits
  always @(negedge clk) begin
    if (ro_mode == 1) begin
      ro_in = 1'($urandom);
    end else begin
      ro_ph = (ro_ph + 1) % ro_period;
      ro_in = (ro_ph < ro_period / 2);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Rising edges of ro_in seen by the edge detector at clock edges e0+1..e0+g;
  // the detector sees ro_in two edges late, with a third for edge history
  function automatic int model_edges(input int e0, input int g);
    int n = 0;
    for (int j = e0 + 1; j <= e0 + g; j++)
      if (hist[(j - 2) % HN] && !hist[(j - 3) % HN]) n++;
    return n;
  endfunction

  // Continuous mode latches at edges e0 + k*(g+1), k >= 1
  function automatic bit latch_between(input int e0, input int g, input int a, input int b);
    for (int l = e0 + g + 1; l <= b; l += g + 1)
      if (l >= a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ctrl_word(input int s, input bit ie, input bit cont,
                                            input bit start, input bit abort);
    logic [3:0] s4;
    s4 = 4'(s);
    return {24'h0, s4, ie, abort, cont, start};
  endfunction

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output logic [31:0] r, output logic acked);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = be;
    acked = 1'b0;
    r = '0;
    for (int i = 0; i < 4 && !acked; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        acked = 1'b1;
        r = rdat;
        last_hit = cyc_cnt - 1;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] off, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    logic a;
    wb_xfer(1'b1, BASE + off, d, be, r, a);
    check("write ack", 32'(a), 32'd1);
  endtask

  task automatic wb_read(input logic [31:0] off, output logic [31:0] d);
    logic a;
    wb_xfer(1'b0, BASE + off, 32'h0, 4'hF, d, a);
    check("read ack", 32'(a), 32'd1);
  endtask

  // Poll STATUS, checking BUSY/DONE/OVF against the window timing, then COUNT
  task automatic finish_meas(input int e0, input int g, input string tag);
    logic [31:0] st, cnt, exp_st;
    logic busy_e, done_e, ovf_e, seen;
    int x, n;
    seen = 1'b0;
    n = 0;
    for (int k = 0; k < g + 40 && !seen; k++) begin
      wb_read(32'hC, st);
      x = last_hit - 1;
      busy_e = (x >= e0) && (x <= e0 + g);
      done_e = (x >= e0 + g + 1);
      ovf_e  = 1'b0;
      if (done_e) begin
        n = model_edges(e0, g);
        ovf_e = (n > MAXC);
      end
      exp_st = {29'h0, ovf_e, done_e, busy_e};
      check({tag, " status"}, st, exp_st);
      seen = st[1] | done_e;
    end
    check({tag, " done seen"}, 32'(seen), 32'd1);
    wb_read(32'h8, cnt);
    check({tag, " count"}, cnt, 32'((n > MAXC) ? MAXC : n));
  endtask

  task automatic clear_status();
    logic [31:0] st;
    wb_write(32'hC, 32'h6, 4'h1);
    wb_read(32'hC, st);
    check("status cleared", st, 32'h0);
  endtask

  initial begin
    logic [31:0] d, st;
    logic a;
    int e0, g, s, hw, x;
    logic [31:0] exp_ctrl;

    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Mid-window reset discards the measurement and all register state
    wb_write(32'h0, ctrl_word(3, 1'b0, 1'b0, 1'b0, 1'b0), 4'h1);
    wb_write(32'h4, 32'd500, 4'hF);
    wb_write(32'h0, ctrl_word(3, 1'b0, 1'b0, 1'b1, 1'b0), 4'h1);
    repeat (20) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ro_sel", 32'(ro_sel), 32'h0);
    check("reset ack", 32'(ack), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    wb_read(32'h0, d); check("reset CTRL", d, 32'h0);
    wb_read(32'h4, d); check("reset GATE", d, 32'h0);
    wb_read(32'h8, d); check("reset COUNT", d, 32'h0);
    wb_read(32'hC, d); check("reset STATUS", d, 32'h0);

    // Basic measurement: SEL=5, GATE=96, period 8
    ro_mode = 0; ro_period = 8;
    wb_write(32'h0, ctrl_word(5, 1'b0, 1'b0, 1'b0, 1'b0), 4'h1);
    wb_write(32'h4, 32'd96, 4'hF);
    wb_write(32'h0, ctrl_word(5, 1'b0, 1'b0, 1'b1, 1'b0), 4'h1);
    e0 = last_hit;
    check("basic ro_sel", 32'(ro_sel), 32'd5);
    finish_meas(e0, 96, "basic");
    @(posedge clk); #1;
    check("dat idle zero", rdat, 32'h0);
    clear_status();

    // Randomized single-shot windows
    for (int it = 0; it < 6; it++) begin
      ro_mode   = int'($urandom_range(0, 1));
      ro_period = int'($urandom_range(2, 12));
      g         = int'($urandom_range(1, 1200));
      s         = int'($urandom_range(0, 15));
      wb_write(32'h0, ctrl_word(s, 1'b0, 1'b0, 1'b0, 1'b0), 4'h1);
      wb_write(32'h4, 32'(g), 4'hF);
      wb_read(32'h4, d); check("rand GATE", d, 32'(g));
      wb_write(32'h0, ctrl_word(s, 1'b0, 1'b0, 1'b1, 1'b0), 4'h1);
      e0 = last_hit;
      check("rand ro_sel", 32'(ro_sel), 32'(s));
      finish_meas(e0, g, "rand");
      clear_status();
    end

    // Saturation: 500 edges into an 8-bit counter
    ro_mode = 0; ro_period = 4;
    wb_write(32'h4, 32'd2000, 4'hF);
    wb_write(32'h0, ctrl_word(0, 1'b0, 1'b0, 1'b1, 1'b0), 4'h1);
    e0 = last_hit;
    finish_meas(e0, 2000, "sat");
    clear_status();

    // Zero-length gate goes straight to LATCH
    wb_write(32'h4, 32'd0, 4'hF);
    wb_write(32'h0, ctrl_word(0, 1'b0, 1'b0, 1'b1, 1'b0), 4'h1);
    e0 = last_hit;
    finish_meas(e0, 0, "gate0");
    clear_status();

    // SEL/GATE writes and a second START are ignored while busy
    ro_mode = 1;
    wb_write(32'h0, ctrl_word(6, 1'b0, 1'b0, 1'b0, 1'b0), 4'h1);
    wb_write(32'h4, 32'd200, 4'hF);
    wb_write(32'h0, ctrl_word(6, 1'b0, 1'b0, 1'b1, 1'b0), 4'h1);
    e0 = last_hit;
    wb_write(32'h4, 32'd7, 4'hF);
    wb_write(32'h0, ctrl_word(9, 1'b0, 1'b0, 1'b1, 1'b0), 4'h1);
    check("busy ro_sel", 32'(ro_sel), 32'd6);
    finish_meas(e0, 200, "busy");
    wb_read(32'h4, d); check("busy GATE", d, 32'd200);
    clear_status();

    // Continuous mode refreshes every GATE+1 clocks; abort stops it
    ro_mode = 0; ro_period = 8; g = 40;
    wb_write(32'h4, 32'(g), 4'hF);
    wb_write(32'h0, ctrl_word(6, 1'b0, 1'b1, 1'b1, 1'b0), 4'h1);
    e0 = last_hit;
    repeat (130) @(posedge clk);
    wb_read(32'h8, d); check("cont COUNT", d, 32'(g / ro_period));
    wb_read(32'hC, st); check("cont STATUS", st, 32'h3);
    wb_write(32'hC, 32'h2, 4'h1);
    hw = last_hit;
    wb_read(32'hC, st);
    x = last_hit - 1;
    check("cont after W1C", st, {29'h0, 1'b0, latch_between(e0, g, hw, x), 1'b1});
    repeat (45) @(posedge clk);
    wb_read(32'hC, st);
    x = last_hit - 1;
    check("cont refresh", st, {29'h0, 1'b0, latch_between(e0, g, hw, x), 1'b1});
    wb_write(32'h0, ctrl_word(6, 1'b0, 1'b0, 1'b0, 1'b1), 4'h1);
    wb_read(32'hC, st); check("abort busy", 32'(st[0]), 32'h0);
    wb_read(32'h8, d); check("abort COUNT", d, 32'(g / ro_period));
    repeat (60) @(posedge clk);
    wb_read(32'hC, st); check("abort stays idle", 32'(st[0]), 32'h0);
    clear_status();

    // CTRL readback: START/ABORT read 0, IE only with the interrupt option
`ifdef RO_FREQ_COUNTER_IRQ_EN
    exp_ctrl = 32'hFA;
`else
    exp_ctrl = 32'hF2;
`endif
    wb_write(32'h0, 32'hFA, 4'h1);
    wb_read(32'h0, d); check("CTRL readback", d, exp_ctrl);
    check("CTRL ro_sel", 32'(ro_sel), 32'hF);
    wb_write(32'h0, 32'h0, 4'h1);
    wb_read(32'h0, d); check("CTRL cleared", d, 32'h0);

    // Byte-lane writes to GATE
    wb_write(32'h4, 32'h0001_2345, 4'hF);
    wb_write(32'h4, 32'hAABB_CCDD, 4'b0010);
    wb_read(32'h4, d); check("GATE byte lane", d, 32'h0001_CC45);

    // Out-of-window addresses are not acknowledged
    wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, d, a);
    check("unmapped +0x10 ack", 32'(a), 32'h0);
    wb_xfer(1'b1, BASE + 32'h1000, 32'h1, 4'hF, d, a);
    check("unmapped +0x1000 ack", 32'(a), 32'h0);

`ifdef RO_FREQ_COUNTER_IRQ_EN
    // Interrupt follows DONE when enabled
    wb_write(32'h4, 32'd10, 4'hF);
    check("irq idle", 32'(irq), 32'h0);
    wb_write(32'h0, ctrl_word(0, 1'b1, 1'b0, 1'b1, 1'b0), 4'h1);
    e0 = last_hit;
    finish_meas(e0, 10, "irq");
    check("irq set", 32'(irq), 32'h1);
    wb_write(32'hC, 32'h2, 4'h1);
    check("irq cleared", 32'(irq), 32'h0);
    wb_write(32'h0, ctrl_word(0, 1'b0, 1'b0, 1'b1, 1'b0), 4'h1);
    e0 = last_hit;
    finish_meas(e0, 10, "irq off");
    repeat (3) @(posedge clk); #1;
    check("irq disabled", 32'(irq), 32'h0);
    clear_status();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
